// File: rtl/key_debouncer_pkg.sv
// Shared constants and helpers for the pushbutton debouncer.
package key_debouncer_pkg;

    // 20 ms of stable input at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Pushbuttons are active-low, so "released" is a logic one.
    localparam logic KEY_RELEASED_N = 1'b1;

    // Width of a counter that must reach DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: synchronizer, stability counter, accepted level and
// one-cycle press/release pulses aligned with the accepted level change.
module key_debounce_ch
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_in_clk,
    input  logic reset_in_reset_n,
    input  logic key_raw_n,
    output logic key_stable_n,
    output logic key_press,
    output logic key_release
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_bit;

    // The raw pin is only ever read here; the last stage feeds the debouncer.
    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Shift the raw pin into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_raw_n};
    end

    // Count consecutive cycles of disagreement; accept on the last one, any
    // agreement in between drops the count back to zero.
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_bit != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d  = sync_bit;
                press_d   = ~sync_bit;
                release_d = sync_bit;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state; reset returns to "released" and drops any pending count.
    always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
        if (!reset_in_reset_n) begin
            sync_q    <= {SYNC_STAGES{KEY_RELEASED_N}};
            stable_q  <= KEY_RELEASED_N;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_stable_n = stable_q;
    assign key_press    = press_q;
    assign key_release  = release_q;

endmodule

// File: rtl/key_debouncer.sv
// N_KEYS independent pushbutton debouncers plus a shared press-event counter.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk_in_clk,
    input  logic              reset_in_reset_n,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] key_stable_n,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [15:0]       key_event_count
);

    logic [15:0] ev_q, ev_d;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk_in_clk       (clk_in_clk),
            .reset_in_reset_n (reset_in_reset_n),
            .key_raw_n        (key_raw_n[g]),
            .key_stable_n     (key_stable_n[g]),
            .key_press        (key_press[g]),
            .key_release      (key_release[g])
        );
    end

    // Add every press pulse of this cycle; the 16-bit sum wraps naturally.
    always_comb begin
        ev_d = ev_q;
        for (int i = 0; i < N_KEYS; i++) begin
            ev_d = ev_d + 16'(key_press[i]);
        end
    end

    // Event counter register.
    always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
        if (!reset_in_reset_n) ev_q <= '0;
        else                   ev_q <= ev_d;
    end

    assign key_event_count = ev_q;

endmodule
